mp_seq_ctrl: RTL
================

Name: mp_seq_ctrl

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator mini processor (ACC, EXT, R[0..15], c_b flag, 16-entry instruction memory).
- Owns the pc and latches the instruction word.
- Issues per-instruction write strobes and ALU op to the datapath.
- Sequences the 8-iteration restoring divide one step per cycle instead of in a single cycle.
- Handles branches, halt and fetch stalls.

Parameters:
PC_W, 8, pc width; wraps modulo 2^PC_W.
DIV_STEPS, 8, number of div_step cycles per divide (one per quotient bit).
CNT_W, 16, width of retired-instruction counter.

Ports:
slow_clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
start  in  1  level; leaves IDLE when high; ignored in all other states.
instr  in  8  instruction word at imem[pc]; combinational read by the datapath.
instr_valid  in  1  instr is valid this cycle; low = fetch stall.
c_b  in  1  registered carry/borrow flag from datapath.
pc  out  PC_W  program counter; drives imem address.
opcode_q  out  4  latched instr[7:4].
addr_q  out  4  latched instr[3:0]; register index, sub-op or branch target.
alu_op  out  4  equals opcode_q in EXEC; 0 otherwise.
acc_we  out  1  datapath loads ACC at end of this cycle.
ext_we  out  1  datapath loads EXT.
flag_we  out  1  datapath loads c_b.
reg_we  out  1  R[addr_q] <= ACC.
div_init  out  1  load dividend/divisor; clear ACC/EXT.
div_step  out  1  perform one shift/subtract divide iteration.
halted  out  1  sticky halt indicator.
instr_count  out  CNT_W  retired instructions; saturates at all-ones.

Behaviour:
- States: IDLE, FETCH, EXEC, DIV, HALT.
- Reset (rst high at posedge): state=IDLE, pc=0, opcode_q=0, addr_q=0, div counter=0, halted=0, instr_count=0. All strobes are combinational from state/IR and forced 0 whenever state≠EXEC/DIV or rst=1.
- Reset takes priority in every state, including mid-divide: next cycle is IDLE with no strobes.
- IDLE: start=1 -> FETCH.
- FETCH: if instr_valid, latch opcode_q/addr_q <= instr and go to EXEC; else stay in FETCH. No strobes while in FETCH. pc is stable throughout FETCH.
- EXEC: exactly one cycle. Decode by opcode_q:
  - 0 with sub 1-5: acc_we.
  - 0 with sub 6-7: acc_we, flag_we.
  - 0 with other sub values: NOP.
  - 1, 2: acc_we, flag_we.
  - 3: acc_we, ext_we.
  - 4: div_init; go to DIV with counter=0; pc not advanced yet.
  - 5, 6, 7, 9: acc_we.
  - 8: pc <= addr_q (zero-extended) if c_b=1, else pc+1. c_b is sampled in the EXEC cycle.
  - A: reg_we.
  - B: pc <= addr_q unconditionally.
  - C, D, E: NOP.
  - F: go to HALT, set halted=1; pc unchanged; not counted as retired.
- After EXEC, every non-branch, non-divide, non-halt opcode does pc <= pc+1 (0xFF -> 0x00), instr_count+1, next state FETCH.
- DIV: div_step=1 every cycle for DIV_STEPS cycles (counter 0..DIV_STEPS-1). In the last cycle: pc+1, instr_count+1, -> FETCH. No other strobe is asserted in DIV.
- HALT: absorbing until rst; start is ignored; all strobes 0.
- Latency: 2 cycles per instruction (FETCH+EXEC) with instr_valid high; divide takes 2+DIV_STEPS = 10 cycles.
- At most one of acc_we/reg_we/div_init/div_step is asserted per cycle (ext_we and flag_we only ever accompany acc_we).

Decomposition:
- Shared package mp_pkg:
  - Opcode constants OP_SHIFT=4'h0 … OP_HALT=4'hF.
  - Shift sub-op constants SUB_SHL=1 … SUB_DEC=7.
  - State enum.
  - PC_W default.
- Sub-module mp_decode: combinational; opcode_q/addr_q/c_b -> strobes and branch decision. mp_seq_ctrl holds the state register, pc, div counter and instr_count.

Test Plan:
1. rst, start=1, instr_valid=1, imem[0]=0x91 -> acc_we=1 and alu_op=9 in cycle 2; pc=1 and instr_count=1 after cycle 2.
2. instr=0x45 -> div_init for 1 cycle, then div_step high for exactly 8 cycles. acc_we stays 0. pc advances once, 10 cycles after FETCH entry; instr_count+1.
3. Branches:
   - 0x85 with c_b=1 -> pc=5.
   - 0x85 with c_b=0 at pc=3 -> pc=4.
   - 0xB2 -> pc=2; flag_we/acc_we stay 0.
4. pc=0xFF executing 0x06 -> acc_we, flag_we in EXEC; pc wraps to 0x00.
5. instr_valid low 3 cycles in FETCH -> state held, no strobes, pc and opcode_q unchanged; proceeds on 4th cycle.
6. Halt and reset:
   - 0xFF -> halted=1, stays halted with start=1 for 5 cycles, instr_count unchanged.
   - rst asserted in 4th div_step cycle -> next cycle IDLE, pc=0, div_step=0, halted=0.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared constants and types for the mini processor sequencer.
package mp_pkg;

   localparam int unsigned PC_W_DEF = 8;

   // Opcodes (instr[7:4])
   localparam logic [3:0] OP_SHIFT = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_MUL   = 4'h3;
   localparam logic [3:0] OP_DIV   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_BRC   = 4'h8;
   localparam logic [3:0] OP_LDR   = 4'h9;
   localparam logic [3:0] OP_STR   = 4'hA;
   localparam logic [3:0] OP_JMP   = 4'hB;
   localparam logic [3:0] OP_NOPC  = 4'hC;
   localparam logic [3:0] OP_NOPD  = 4'hD;
   localparam logic [3:0] OP_NOPE  = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Shift-group sub-ops (instr[3:0] when opcode is OP_SHIFT)
   localparam logic [3:0] SUB_SHL = 4'h1;
   localparam logic [3:0] SUB_SHR = 4'h2;
   localparam logic [3:0] SUB_ROL = 4'h3;
   localparam logic [3:0] SUB_ROR = 4'h4;
   localparam logic [3:0] SUB_NOT = 4'h5;
   localparam logic [3:0] SUB_INC = 4'h6;
   localparam logic [3:0] SUB_DEC = 4'h7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_DIV,
      ST_HALT
   } state_t;

   // Per-instruction datapath write strobes produced by the decoder
   typedef struct packed {
      logic acc_we;
      logic ext_we;
      logic flag_we;
      logic reg_we;
      logic div_init;
   } strobe_t;

endpackage

// File: rtl/mp_decode.sv
// Combinational instruction decoder: latched IR and carry flag to
// datapath strobes, branch decision and control-flow class.
module mp_decode
   import mp_pkg::*;
(
   input  logic [3:0] opcode_q,
   input  logic [3:0] addr_q,
   input  logic       c_b,
   output strobe_t    strb,
   output logic       pc_load,
   output logic       is_halt
);

   // Decode opcode (and shift sub-op) into strobes and pc behaviour
   always_comb begin
      strb    = '0;
      pc_load = 1'b0;
      is_halt = 1'b0;
      case (opcode_q)
         OP_SHIFT: begin
            case (addr_q)
               SUB_SHL, SUB_SHR, SUB_ROL, SUB_ROR, SUB_NOT: strb.acc_we = 1'b1;
               SUB_INC, SUB_DEC: begin
                  strb.acc_we  = 1'b1;
                  strb.flag_we = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ADD, OP_SUB: begin
            strb.acc_we  = 1'b1;
            strb.flag_we = 1'b1;
         end
         OP_MUL: begin
            strb.acc_we = 1'b1;
            strb.ext_we = 1'b1;
         end
         OP_DIV:                        strb.div_init = 1'b1;
         OP_AND, OP_OR, OP_XOR, OP_LDR: strb.acc_we   = 1'b1;
         OP_BRC:                        pc_load       = c_b;
         OP_STR:                        strb.reg_we   = 1'b1;
         OP_JMP:                        pc_load       = 1'b1;
         OP_NOPC, OP_NOPD, OP_NOPE: ;
         OP_HALT:                       is_halt       = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mp_seq_ctrl.sv
// Fetch/decode/execute sequencer: owns pc, IR, divide step counter and
// retired-instruction counter; strobes are combinational from state/IR.
module mp_seq_ctrl
   import mp_pkg::*;
#(
   parameter int unsigned PC_W      = PC_W_DEF,
   parameter int unsigned DIV_STEPS = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             slow_clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       instr,
   input  logic             instr_valid,
   input  logic             c_b,
   output logic [PC_W-1:0]  pc,
   output logic [3:0]       opcode_q,
   output logic [3:0]       addr_q,
   output logic [3:0]       alu_op,
   output logic             acc_we,
   output logic             ext_we,
   output logic             flag_we,
   output logic             reg_we,
   output logic             div_init,
   output logic             div_step,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   localparam int unsigned       DCNT_W    = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV_STEPS - 1);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_d;
   logic [DCNT_W-1:0] div_cnt_q, div_cnt_d;
   logic              latch_ir;
   logic              retire;
   logic              set_halt;

   strobe_t dec_strb;
   logic    dec_pc_load;
   logic    dec_is_halt;

   mp_decode u_decode (
      .opcode_q (opcode_q),
      .addr_q   (addr_q),
      .c_b      (c_b),
      .strb     (dec_strb),
      .pc_load  (dec_pc_load),
      .is_halt  (dec_is_halt)
   );

   // Next-state, next-pc and strobe generation
   always_comb begin
      state_d   = state_q;
      pc_d      = pc;
      div_cnt_d = div_cnt_q;
      latch_ir  = 1'b0;
      retire    = 1'b0;
      set_halt  = 1'b0;
      alu_op    = '0;
      acc_we    = 1'b0;
      ext_we    = 1'b0;
      flag_we   = 1'b0;
      reg_we    = 1'b0;
      div_init  = 1'b0;
      div_step  = 1'b0;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            if (instr_valid) begin
               latch_ir = 1'b1;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_op   = opcode_q;
            acc_we   = dec_strb.acc_we;
            ext_we   = dec_strb.ext_we;
            flag_we  = dec_strb.flag_we;
            reg_we   = dec_strb.reg_we;
            div_init = dec_strb.div_init;
            if (dec_is_halt) begin
               set_halt = 1'b1;
               state_d  = ST_HALT;
            end else if (dec_strb.div_init) begin
               // pc/count advance is deferred to the final divide step
               div_cnt_d = '0;
               state_d   = ST_DIV;
            end else begin
               retire  = 1'b1;
               pc_d    = dec_pc_load ? PC_W'(addr_q) : pc + PC_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_DIV: begin
            div_step = 1'b1;
            if (div_cnt_q == DCNT_LAST) begin
               retire    = 1'b1;
               pc_d      = pc + PC_W'(1);
               div_cnt_d = '0;
               state_d   = ST_FETCH;
            end else begin
               div_cnt_d = div_cnt_q + DCNT_W'(1);
            end
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase
      // Reset suppresses every strobe in the same cycle it is asserted
      if (rst) begin
         alu_op   = '0;
         acc_we   = 1'b0;
         ext_we   = 1'b0;
         flag_we  = 1'b0;
         reg_we   = 1'b0;
         div_init = 1'b0;
         div_step = 1'b0;
      end
   end

   // State, pc, IR, divide counter, halt flag and retired counter
   always_ff @(posedge slow_clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc          <= '0;
         opcode_q    <= '0;
         addr_q      <= '0;
         div_cnt_q   <= '0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         state_q   <= state_d;
         pc        <= pc_d;
         div_cnt_q <= div_cnt_d;
         if (latch_ir) begin
            opcode_q <= instr[7:4];
            addr_q   <= instr[3:0];
         end
         if (set_halt) halted <= 1'b1;
         if (retire && (instr_count != '1)) instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
